// File: rtl/cc_pkg.sv
// Shared definitions for the cache write-back path: FSM state encoding,
// line geometry and the AXI burst/size/response constants.
package cc_pkg;

  localparam int CC_LINE_W = 512;
  localparam int CC_BEATS  = 8;

  localparam logic [3:0] CC_AXI_LEN        = 4'd7;
  localparam logic [2:0] CC_AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] CC_AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] CC_AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_AW,
    WB_W,
    WB_B
  } wb_state_e;

endpackage

// File: rtl/cc_writeback_unit.sv
// Victim-line write-back engine: captures one 512-bit line and issues it as a
// single 8-beat AXI INCR burst. Optional macro CC_WB_RETRY_EN re-issues the burst once on error.
module cc_writeback_unit
  import cc_pkg::*;
#(
  parameter int BEATS  = CC_BEATS,
  parameter int DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_req_valid_i,
  output logic                    wb_req_ready_o,
  input  logic [31:0]             wb_addr_i,
  input  logic [BEATS*DATA_W-1:0] wb_data_i,
  output logic [31:0]             mem_awaddr_o,
  output logic [3:0]              mem_awlen_o,
  output logic [2:0]              mem_awsize_o,
  output logic [1:0]              mem_awburst_o,
  output logic                    mem_awvalid_o,
  input  logic                    mem_awready_i,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic [DATA_W/8-1:0]     mem_wstrb_o,
  output logic                    mem_wlast_o,
  output logic                    mem_wvalid_o,
  input  logic                    mem_wready_i,
  input  logic [1:0]              mem_bresp_i,
  input  logic                    mem_bvalid_i,
  output logic                    mem_bready_o,
  output logic                    wb_done_o,
  output logic                    wb_err_o
);

  localparam int LINE_W = BEATS * DATA_W;
  localparam int CNT_W  = $clog2(BEATS);

  wb_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        addr_reg, addr_next;
  logic [LINE_W-1:0]  line_reg, line_next;
`ifdef CC_WB_RETRY_EN
  logic               retry_reg, retry_next;
`endif

  logic [DATA_W-1:0]  words [BEATS];
  logic               last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_words
      assign words[gi] = line_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign last_beat     = (cnt_reg == CNT_W'(BEATS - 1));
  assign mem_awaddr_o  = addr_reg;
  assign mem_awlen_o   = CC_AXI_LEN;
  assign mem_awsize_o  = CC_AXI_SIZE_8B;
  assign mem_awburst_o = CC_AXI_BURST_INCR;
  assign mem_wdata_o   = words[cnt_reg];
  assign mem_wstrb_o   = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= WB_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      line_reg  <= '0;
`ifdef CC_WB_RETRY_EN
      retry_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      line_reg  <= line_next;
`ifdef CC_WB_RETRY_EN
      retry_reg <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    line_next      = line_reg;
`ifdef CC_WB_RETRY_EN
    retry_next     = retry_reg;
`endif
    wb_req_ready_o = 1'b0;
    mem_awvalid_o  = 1'b0;
    mem_wvalid_o   = 1'b0;
    mem_wlast_o    = 1'b0;
    mem_bready_o   = 1'b0;
    wb_done_o      = 1'b0;
    wb_err_o       = 1'b0;

    case (state_reg)
      WB_IDLE: begin
        wb_req_ready_o = 1'b1;
        if (wb_req_valid_i) begin
          state_next = WB_AW;
          addr_next  = wb_addr_i & 32'hFFFF_FFC0;
          line_next  = wb_data_i;
          cnt_next   = '0;
`ifdef CC_WB_RETRY_EN
          retry_next = 1'b0;
`endif
        end
      end
      WB_AW: begin
        mem_awvalid_o = 1'b1;
        if (mem_awready_i) begin
          state_next = WB_W;
          cnt_next   = '0;
        end
      end
      WB_W: begin
        mem_wvalid_o = 1'b1;
        mem_wlast_o  = last_beat;
        if (mem_wready_i) begin
          if (last_beat) begin
            state_next = WB_B;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      WB_B: begin
        mem_bready_o = 1'b1;
        if (mem_bvalid_i) begin
`ifdef CC_WB_RETRY_EN
          // First error response replays the whole burst instead of finishing.
          if (mem_bresp_i != CC_AXI_RESP_OKAY && !retry_reg) begin
            state_next = WB_AW;
            retry_next = 1'b1;
          end else begin
            state_next = WB_IDLE;
            wb_done_o  = 1'b1;
            wb_err_o   = (mem_bresp_i != CC_AXI_RESP_OKAY);
          end
`else
          state_next = WB_IDLE;
          wb_done_o  = 1'b1;
          wb_err_o   = (mem_bresp_i != CC_AXI_RESP_OKAY);
`endif
        end
      end
      default: state_next = WB_IDLE;
    endcase

    // Reset silences the bus immediately, even mid-burst.
    if (!rst_n) begin
      wb_req_ready_o = 1'b0;
      mem_awvalid_o  = 1'b0;
      mem_wvalid_o   = 1'b0;
      mem_wlast_o    = 1'b0;
      mem_bready_o   = 1'b0;
      wb_done_o      = 1'b0;
      wb_err_o       = 1'b0;
    end
  end

endmodule
